lii_link_fifo: RTL and testbench

//  Elastic LII buffer placed directly downstream of pool1_wrapper's phy output (lii_out_p0_*).

---
 rtl/lii_pkg.sv | 14 +
 rtl/lii_fifo_mem.sv | 18 +
 rtl/lii_link_fifo.sv | 81 ++++++++
 tb/tb_lii_link_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lii_pkg.sv
// lii_pkg: shared LII beat widths and beat type for the link FIFO slice
package lii_pkg;
  localparam int LII_ID_W = 8;
  localparam int LII_PW = 1024;
  localparam int LII_BEAT_W = LII_PW + 2 * LII_ID_W;
  typedef struct packed {
    logic [LII_PW-1:0]   data;
    logic [LII_ID_W-1:0] src;
    logic [LII_ID_W-1:0] dst;
  } lii_beat_t;
  function automatic int lii_beat_w(input int pw);
    return pw + 2 * LII_ID_W;
  endfunction
endpackage

// File: rtl/lii_fifo_mem.sv
// lii_fifo_mem: DEPTH x W storage, one write port, one async read port, no reset
module lii_fifo_mem #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // write the incoming beat at the tail slot
  always_ff @(posedge aclk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lii_link_fifo.sv
// lii_link_fifo: first-word-fall-through LII elastic buffer; LII_LINK_FIFO_STATS_EN adds beat/stall/hold counters
module lii_link_fifo import lii_pkg::*; #(
  parameter int PW = LII_PW,
  parameter int DEPTH = 16,
  parameter int AF_MARGIN = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                aclk,
  input  logic                arstn,
  input  logic [PW-1:0]       lii_in_tdata,
  input  logic                lii_in_tvalid,
  output logic                lii_in_tready,
  input  logic [LII_ID_W-1:0] lii_in_src,
  input  logic [LII_ID_W-1:0] lii_in_dst,
  output logic [PW-1:0]       lii_out_tdata,
  output logic                lii_out_tvalid,
  input  logic                lii_out_tready,
  output logic [LII_ID_W-1:0] lii_out_src,
  output logic [LII_ID_W-1:0] lii_out_dst,
  output logic [CW-1:0]       count,
  output logic                prog_full
`ifdef LII_LINK_FIFO_STATS_EN
  ,
  output logic [31:0]         beat_cnt,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         ovf_hold_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = lii_beat_w(PW);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [BW-1:0] rd_beat;
  logic live, full, empty, push, pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign lii_in_tready = live & ~full;
  assign lii_out_tvalid = ~empty;
  assign push = lii_in_tvalid & lii_in_tready;
  assign pop = lii_out_tvalid & lii_out_tready;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign {lii_out_tdata, lii_out_src, lii_out_dst} = empty ? '0 : rd_beat;
  lii_fifo_mem #(.W(BW), .DEPTH(DEPTH)) u_mem (
    .aclk  (aclk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({lii_in_tdata, lii_in_src, lii_in_dst}),
    .raddr (rd_ptr),
    .rdata (rd_beat)
  );
  // pointers, occupancy, registered almost-full; live holds tready low until the first edge after reset
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      prog_full <= 1'b0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_nxt;
      prog_full <= count_nxt >= CW'(DEPTH - AF_MARGIN);
    end
  end
`ifdef LII_LINK_FIFO_STATS_EN
  // free-running wrap-around traffic counters, cleared only by reset
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      beat_cnt <= '0;
      stall_cnt <= '0;
      ovf_hold_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt + 32'(pop);
      stall_cnt <= stall_cnt + 32'(lii_out_tvalid & ~lii_out_tready);
      ovf_hold_cnt <= ovf_hold_cnt + 32'(lii_in_tvalid & ~lii_in_tready);
    end
  end
`endif
endmodule

// File: tb/tb_lii_link_fifo.sv
// tb_lii_link_fifo: queue-model checked random and directed traffic through lii_link_fifo
module tb_lii_link_fifo;
  localparam int PW = 64;
  localparam int DEPTH = 16;
  localparam int AFM = 2;
  logic aclk = 0, arstn = 0;
  logic [PW-1:0] in_tdata, out_tdata;
  logic in_tvalid, in_tready, out_tvalid, out_tready;
  logic [7:0] in_src, in_dst, out_src, out_dst;
  logic [4:0] count;
  logic prog_full;
`ifdef LII_LINK_FIFO_STATS_EN
  logic [31:0] beat_cnt, stall_cnt, ovf_hold_cnt;
`endif
  int n_chk = 0, n_fail = 0;

  lii_link_fifo #(.PW(PW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .aclk(aclk), .arstn(arstn),
    .lii_in_tdata(in_tdata), .lii_in_tvalid(in_tvalid), .lii_in_tready(in_tready),
    .lii_in_src(in_src), .lii_in_dst(in_dst),
    .lii_out_tdata(out_tdata), .lii_out_tvalid(out_tvalid), .lii_out_tready(out_tready),
    .lii_out_src(out_src), .lii_out_dst(out_dst),
    .count(count), .prog_full(prog_full)
`ifdef LII_LINK_FIFO_STATS_EN
    , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt), .ovf_hold_cnt(ovf_hold_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  logic [PW+15:0] mq[$];
  bit m_live, last_push;
  int unsigned m_beat, m_stall, m_ovf;

  always @(posedge aclk or negedge arstn) begin
    bit tr, tv, pu, po;
    if (!arstn) begin
      mq.delete();
      m_live = 0;
      last_push = 0;
      m_beat = 0;
      m_stall = 0;
      m_ovf = 0;
    end else begin
      tr = m_live && mq.size() < DEPTH;
      tv = mq.size() > 0;
      pu = in_tvalid && tr;
      po = tv && out_tready;
      m_beat += po ? 1 : 0;
      m_stall += (tv && !out_tready) ? 1 : 0;
      m_ovf += (in_tvalid && !tr) ? 1 : 0;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({in_tdata, in_src, in_dst});
      last_push = pu;
      m_live = 1;
    end
  end

  always @(negedge aclk) if (arstn) begin
    logic [PW+15:0] h;
    h = mq.size() > 0 ? mq[0] : '0;
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_tvalid", 64'(out_tvalid), 64'(mq.size() > 0));
    chk("in_tready", 64'(in_tready), 64'(m_live && mq.size() < DEPTH));
    chk("prog_full", 64'(prog_full), 64'(mq.size() >= DEPTH - AFM));
    chk("out_tdata", 64'(out_tdata), 64'(h[PW+15:16]));
    chk("out_src", 64'(out_src), 64'(h[15:8]));
    chk("out_dst", 64'(out_dst), 64'(h[7:0]));
`ifdef LII_LINK_FIFO_STATS_EN
    chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("ovf_hold_cnt", 64'(ovf_hold_cnt), 64'(m_ovf));
`endif
  end

  initial begin
    in_tvalid = 0; in_tdata = '0; in_src = 0; in_dst = 0; out_tready = 0;
    repeat (3) @(negedge aclk);
    chk("rst_count", 64'(count), 0);
    chk("rst_tvalid", 64'(out_tvalid), 0);
    chk("rst_tready", 64'(in_tready), 0);
    chk("rst_tdata", 64'(out_tdata), 0);
    arstn = 1;
    @(negedge aclk);
    chk("tready_after_rst", 64'(in_tready), 1);
    chk("prog_full_after_rst", 64'(prog_full), 0);
    // three beats straight through
    out_tready = 1;
    for (int i = 0; i < 3; i++) begin
      in_tvalid = 1; in_tdata = 64'hA1 + 64'(i); in_src = 1; in_dst = 2;
      @(negedge aclk);
      chk("t1_head", 64'(out_tdata), 64'hA1 + 64'(i));
      chk("t1_count", 64'(count), 1);
    end
    in_tvalid = 0;
    @(negedge aclk);
    chk("t1_empty_count", 64'(count), 0);
    chk("t1_empty_tvalid", 64'(out_tvalid), 0);
    // fill to full with the sink stalled
    out_tready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_tvalid = 1; in_tdata = 64'hB0 + 64'(i); in_src = 8'(i); in_dst = 8'(100 + i);
      @(negedge aclk);
      chk("t2_prog_full", 64'(prog_full), 64'(i + 1 >= DEPTH - AFM));
    end
    in_tdata = 64'hC7; in_src = 8'h77; in_dst = 8'h78;
    repeat (2) @(negedge aclk);
    chk("t2_full_count", 64'(count), 16);
    chk("t2_full_tready", 64'(in_tready), 0);
    chk("t2_full_head", 64'(out_tdata), 64'hB0);
    // full and popping: pop only, then push+pop
    out_tready = 1;
    @(negedge aclk);
    chk("t3_pop_only", 64'(count), 15);
    @(negedge aclk);
    chk("t3_push_pop", 64'(count), 15);
    in_tvalid = 0;
    for (int i = 0; i < 40 && out_tvalid; i++) @(negedge aclk);
    chk("t3_drained", 64'(out_tvalid), 0);
    // 40 beats streaming, pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      in_tvalid = 1; in_tdata = {$urandom, $urandom}; in_src = 8'($urandom); in_dst = 8'($urandom);
      @(negedge aclk);
      chk("t4_count", 64'(count), 1);
    end
    in_tvalid = 0;
    @(negedge aclk);
    // random traffic obeying upstream hold rules
    for (int i = 0; i < 600; i++) begin
      if (!in_tvalid || last_push) begin
        in_tvalid = ($urandom % 4) != 0;
        in_tdata = {$urandom, $urandom}; in_src = 8'($urandom); in_dst = 8'($urandom);
      end
      out_tready = ($urandom % 3) != 0;
      @(negedge aclk);
    end
    in_tvalid = 0; out_tready = 1;
    repeat (20) @(negedge aclk);
    // reset while holding beats
    out_tready = 0;
    for (int i = 0; i < 5; i++) begin
      in_tvalid = 1; in_tdata = 64'hE0 + 64'(i); in_src = 5; in_dst = 6;
      @(negedge aclk);
    end
    in_tvalid = 0;
    chk("t5_loaded", 64'(count), 5);
    #2 arstn = 0;
    #1;
    chk("t5_rst_tvalid", 64'(out_tvalid), 0);
    chk("t5_rst_count", 64'(count), 0);
    chk("t5_rst_tdata", 64'(out_tdata), 0);
`ifdef LII_LINK_FIFO_STATS_EN
    chk("t5_rst_beat_cnt", 64'(beat_cnt), 0);
`endif
    @(negedge aclk);
    arstn = 1;
    out_tready = 1;
    repeat (5) begin
      @(negedge aclk);
      chk("t5_no_old_beats", 64'(out_tvalid), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
